cpu_op_arbiter: RTL and testbench

Front-end controller that shares the serial-loaded 8-bit ALU CPU between two requesters. It accepts complete operations (A, B, opcode) over valid/ready handshakes and arbitrates between the requesters. It serialises the granted operation onto the CPU's start/serial input pins, waits for the result, and returns the result and flags to the requester with an ID tag. It sits between on-chip/host requesters and the CPU top's `ui_in[5:0]`, `uo_out` and `uio_out[3:0]`.

---
 rtl/cpu_op_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_cpu_op_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_op_arbiter.sv
// Two-requester front end for the serial-loaded 8-bit ALU CPU: arbitrate, serialise {A,B,op}, capture result.
// Define CPU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request; the granted requester sees ready high
// S_START | one-cycle cpu_start pulse, serial line held low
// S_SHIFT | 21 operand/opcode bits driven MSB first on cpu_serial
// S_WAIT  | RESULT_WAIT cycles for the CPU result to settle, then capture
// S_RESP  | one-cycle rsp_valid pulse back to the answered requester

module cpu_op_arbiter #(
    parameter int RESULT_WAIT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req0_b,
    input  logic [7:0] i_req1_b,
    input  logic [4:0] i_req0_op,
    input  logic [4:0] i_req1_op,
    output logic       o_req0_ready,
    output logic       o_req1_ready,
    output logic       o_rsp_valid,
    output logic       o_rsp_id,
    output logic [7:0] o_rsp_y,
    output logic [3:0] o_rsp_flags,
    output logic       o_busy,
    output logic       o_cpu_start,
    output logic       o_cpu_serial,
    output logic       o_cpu_manual,
    input  logic [7:0] i_cpu_y,
    input  logic [3:0] i_cpu_flags
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [4:0] SHIFT_LOAD = 5'd20;
    localparam logic [3:0] WAIT_LOAD  = 4'(RESULT_WAIT - 1);

    state_t      r_state;
    logic [20:0] r_sreg;
    logic [4:0]  r_bit_cnt;
    logic [3:0]  r_wait_cnt;
    logic        r_cur_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [7:0]  r_rsp_y;
    logic [3:0]  r_rsp_flags;
    logic        r_busy;
    logic        r_cpu_start;
    logic        r_cpu_serial;

    logic        w_idle;
    logic        w_any_valid;
    logic        w_grant;
    logic        w_accept;
    logic [20:0] w_payload;

    assign w_idle      = (r_state == S_IDLE);
    assign w_any_valid = i_req0_valid | i_req1_valid;
    assign w_accept    = w_idle & w_any_valid;

`ifdef CPU_ARB_RR_EN
    logic r_last_grant;

    always_comb begin
        w_grant = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = i_req1_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`else
    always_comb begin
        w_grant = 1'b0;
        if (!i_req0_valid && i_req1_valid) begin
            w_grant = 1'b1;
        end
    end
`endif

    // Ready is the only combinational output; it only rises for an actual requester.
    assign o_req0_ready = w_accept & ~w_grant;
    assign o_req1_ready = w_accept &  w_grant;

    assign w_payload = w_grant ? {i_req1_a, i_req1_b, i_req1_op}
                               : {i_req0_a, i_req0_b, i_req0_op};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_cur_id     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_y      <= '0;
            r_rsp_flags  <= '0;
            r_busy       <= 1'b0;
            r_cpu_start  <= 1'b0;
            r_cpu_serial <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sreg      <= w_payload;
                        r_cur_id    <= w_grant;
                        r_busy      <= 1'b1;
                        r_cpu_start <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_cpu_start  <= 1'b0;
                    r_cpu_serial <= r_sreg[20];
                    r_sreg       <= {r_sreg[19:0], 1'b0};
                    r_bit_cnt    <= SHIFT_LOAD;
                    r_state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_bit_cnt == 5'd0) begin
                        r_cpu_serial <= 1'b0;
                        r_wait_cnt   <= WAIT_LOAD;
                        r_state      <= S_WAIT;
                    end else begin
                        r_cpu_serial <= r_sreg[20];
                        r_sreg       <= {r_sreg[19:0], 1'b0};
                        r_bit_cnt    <= r_bit_cnt - 5'd1;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_rsp_y     <= i_cpu_y;
                        r_rsp_flags <= i_cpu_flags;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cpu_start  <= 1'b0;
                    r_cpu_serial <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_y      = r_rsp_y;
    assign o_rsp_flags  = r_rsp_flags;
    assign o_busy       = r_busy;
    assign o_cpu_start  = r_cpu_start;
    assign o_cpu_serial = r_cpu_serial;
    assign o_cpu_manual = 1'b0;

endmodule

// File: tb/tb_cpu_op_arbiter.sv
// Directed bench for cpu_op_arbiter with a behavioural serial-loaded ALU CPU standing in for the CPU top.
`timescale 1ns/1ps

module tb_cpu_op_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
    logic [4:0] req0_op = '0, req1_op = '0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0] rsp_y;
    logic [3:0] rsp_flags;
    logic       cpu_start, cpu_serial, cpu_manual;
    logic [7:0] cpu_y;
    logic [3:0] cpu_flags;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cpu_op_arbiter #(.RESULT_WAIT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
        .i_req0_a(req0_a), .i_req1_a(req1_a),
        .i_req0_b(req0_b), .i_req1_b(req1_b),
        .i_req0_op(req0_op), .i_req1_op(req1_op),
        .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_y(rsp_y), .o_rsp_flags(rsp_flags),
        .o_busy(busy), .o_cpu_start(cpu_start), .o_cpu_serial(cpu_serial),
        .o_cpu_manual(cpu_manual), .i_cpu_y(cpu_y), .i_cpu_flags(cpu_flags)
    );

    // CPU stand-in: start clears the loader, 21 bits shift in MSB first, ALU output is combinational.
    // Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A. Flags {N,V,Z,C}, C on SUB = no borrow.
    logic [20:0] m_sh;
    int          m_cnt;
    logic [7:0]  m_a, m_b;
    logic [4:0]  m_op;
    logic [8:0]  m_sum;
    logic        m_v, m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh  <= '0;
            m_cnt <= 21;
        end else if (cpu_start) begin
            m_cnt <= 0;
        end else if (m_cnt < 21) begin
            m_sh  <= {m_sh[19:0], cpu_serial};
            m_cnt <= m_cnt + 1;
        end
    end

    always_comb begin
        m_a = m_sh[20:13];
        m_b = m_sh[12:5];
        m_op = m_sh[4:0];
        m_sum = '0;
        m_v = 1'b0;
        m_c = 1'b0;
        cpu_y = m_a;
        case (m_op)
            5'd0: begin
                m_sum = {1'b0, m_a} + {1'b0, m_b};
                cpu_y = m_sum[7:0];
                m_c = m_sum[8];
                m_v = (m_a[7] == m_b[7]) && (cpu_y[7] != m_a[7]);
            end
            5'd1: begin
                m_sum = {1'b0, m_a} + {1'b0, ~m_b} + 9'd1;
                cpu_y = m_sum[7:0];
                m_c = m_sum[8];
                m_v = (m_a[7] != m_b[7]) && (cpu_y[7] != m_a[7]);
            end
            5'd2: cpu_y = m_a & m_b;
            5'd3: cpu_y = m_a | m_b;
            5'd4: cpu_y = m_a ^ m_b;
            default: cpu_y = m_a;
        endcase
        cpu_flags = {cpu_y[7], m_v, (cpu_y == 8'd0), m_c};
    end

    // Event log sampled on the falling edge.
    int         acc_cyc_q[$];
    int         acc_id_q[$];
    int         rsp_cyc_q[$];
    int         rsp_id_q[$];
    logic [7:0] rsp_y_q[$];
    logic [3:0] rsp_f_q[$];
    int         busy_low_q[$];
    int         last_start = -100;
    int         overlap_cnt = 0;

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(0); end
        if (req1_valid && req1_ready) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(1); end
        if (rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            rsp_id_q.push_back(int'(rsp_id));
            rsp_y_q.push_back(rsp_y);
            rsp_f_q.push_back(rsp_flags);
        end
        if (!busy) busy_low_q.push_back(cyc);
        if (cpu_start) begin
            if (cyc - last_start < 23) overlap_cnt++;
            last_start = cyc;
        end
    end

    task automatic clear_log();
        acc_cyc_q.delete(); acc_id_q.delete();
        rsp_cyc_q.delete(); rsp_id_q.delete(); rsp_y_q.delete(); rsp_f_q.delete();
        busy_low_q.delete();
    endtask

    task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
        bit ok = 0;
        @(posedge clk); #1;
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) ok = 1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: requester %0d never saw ready", id);
        end
    endtask

    task automatic wait_rsps(input int n, input int limit);
        for (int i = 0; i < limit && rsp_y_q.size() < n; i++) begin
            @(negedge clk); #1;
        end
        total++;
        if (rsp_y_q.size() < n) begin
            bad++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_y_q.size(), n);
        end
    endtask

    function automatic logic [19:0] out_vec();
        return {rsp_valid, rsp_id, rsp_y, rsp_flags, busy, cpu_start, cpu_serial, cpu_manual, req0_ready, req1_ready};
    endfunction

    task automatic test_reset();
        logic [19:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        v = out_vec();
        total++;
        if (v !== 20'd0) begin bad++; $display("FAIL reset_outputs: got %h required 0", v); end
        rst_n = 1'b1;
        @(negedge clk);
        v = out_vec();
        total++;
        if (v !== 20'd0) begin bad++; $display("FAIL post_reset_idle: got %h required 0", v); end
    endtask

    task automatic test_single_add();
        clear_log();
        send(1'b0, 8'd11, 8'd15, 5'd0);
        wait_rsps(1, 60);
        repeat (4) @(negedge clk);
        if (rsp_y_q.size() >= 1 && acc_cyc_q.size() >= 1) begin
            total++;
            if (rsp_cyc_q[0] - acc_cyc_q[0] !== 26) begin bad++; $display("FAIL add_latency: got %0d required 26", rsp_cyc_q[0] - acc_cyc_q[0]); end
            total++;
            if (rsp_id_q[0] !== 0) begin bad++; $display("FAIL add_id: got %0d required 0", rsp_id_q[0]); end
            total++;
            if (rsp_y_q[0] !== 8'd26) begin bad++; $display("FAIL add_y: got %0d required 26", rsp_y_q[0]); end
            total++;
            if (rsp_f_q[0] !== 4'b0000) begin bad++; $display("FAIL add_flags: got %b required 0000", rsp_f_q[0]); end
        end
        total++;
        if (rsp_y_q.size() !== 1) begin bad++; $display("FAIL add_pulse_width: got %0d rsp cycles required 1", rsp_y_q.size()); end
        total++;
        if (busy !== 1'b0 || rsp_y !== 8'd26) begin bad++; $display("FAIL add_hold: busy=%b y=%0d required busy=0 y=26", busy, rsp_y); end
    endtask

    task automatic test_overflow();
        clear_log();
        send(1'b1, 8'd127, 8'd1, 5'd0);
        wait_rsps(1, 60);
        if (rsp_y_q.size() >= 1) begin
            total++;
            if (rsp_id_q[0] !== 1) begin bad++; $display("FAIL ovf_id: got %0d required 1", rsp_id_q[0]); end
            total++;
            if (rsp_y_q[0] !== 8'd128) begin bad++; $display("FAIL ovf_y: got %0d required 128", rsp_y_q[0]); end
            total++;
            if (rsp_f_q[0] !== 4'b1100) begin bad++; $display("FAIL ovf_flags: got %b required 1100", rsp_f_q[0]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_id;
        logic [7:0] exp_y;
        clear_log();
        overlap_cnt = 0;
        @(posedge clk); #1;
        req0_a = 8'd6;   req0_b = 8'd9;   req0_op = 5'd4; req0_valid = 1'b1;
        req1_a = 8'd200; req1_b = 8'd150; req1_op = 5'd1; req1_valid = 1'b1;
        wait_rsps(4, 300);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4 && i < rsp_y_q.size(); i++) begin
`ifdef CPU_ARB_RR_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            exp_y = (exp_id == 0) ? 8'd15 : 8'd50;
            total++;
            if (rsp_id_q[i] !== exp_id) begin bad++; $display("FAIL rr_id[%0d]: got %0d required %0d", i, rsp_id_q[i], exp_id); end
            total++;
            if (rsp_y_q[i] !== exp_y) begin bad++; $display("FAIL rr_y[%0d]: got %0d required %0d", i, rsp_y_q[i], exp_y); end
        end
        total++;
        if (overlap_cnt !== 0) begin bad++; $display("FAIL rr_start_overlap: got %0d required 0", overlap_cnt); end
        total++;
        if (acc_cyc_q.size() !== 4) begin bad++; $display("FAIL rr_accept_count: got %0d required 4", acc_cyc_q.size()); end
    endtask

    task automatic test_serial_waveform();
        logic [20:0] exp_bits;
        logic [20:0] got_bits;
        bit start_ok = 1;
        exp_bits = 21'b1010_0101_0011_1100_10010;
        got_bits = '0;
        clear_log();
        send(1'b0, 8'hA5, 8'h3C, 5'h12);
        @(negedge clk);
        total++;
        if (cpu_start !== 1'b1 || cpu_serial !== 1'b0) begin
            bad++; $display("FAIL ser_start: start=%b serial=%b required 1/0", cpu_start, cpu_serial);
        end
        for (int i = 20; i >= 0; i--) begin
            @(negedge clk);
            got_bits[i] = cpu_serial;
            if (cpu_start !== 1'b0) start_ok = 0;
        end
        total++;
        if (got_bits !== exp_bits || !start_ok) begin
            bad++; $display("FAIL ser_bits: got %b start_single=%0d required %b", got_bits, start_ok, exp_bits);
        end
        @(negedge clk);
        total++;
        if (cpu_serial !== 1'b0 || cpu_start !== 1'b0) begin
            bad++; $display("FAIL ser_tail: serial=%b start=%b required 0/0", cpu_serial, cpu_start);
        end
        wait_rsps(1, 40);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [19:0] v;
        clear_log();
        send(1'b0, 8'h55, 8'hAA, 5'd3);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        v = out_vec();
        total++;
        if (v !== 20'd0) begin bad++; $display("FAIL midreset_outputs: got %h required 0", v); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        send(1'b1, 8'd1, 8'd1, 5'd0);
        wait_rsps(1, 60);
        if (rsp_y_q.size() >= 1) begin
            total++;
            if (rsp_y_q[0] !== 8'd2) begin bad++; $display("FAIL midreset_y: got %0d required 2", rsp_y_q[0]); end
            total++;
            if (rsp_id_q[0] !== 1) begin bad++; $display("FAIL midreset_id: got %0d required 1", rsp_id_q[0]); end
            total++;
            if (rsp_cyc_q[0] - acc_cyc_q[0] !== 26) begin bad++; $display("FAIL midreset_latency: got %0d required 26", rsp_cyc_q[0] - acc_cyc_q[0]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_v[3];
        logic [7:0] b_v[3];
        logic [7:0] y_v[3];
        int k = 0;
        int lows;
        a_v = '{8'd1, 8'd10, 8'd100};
        b_v = '{8'd2, 8'd20, 8'd100};
        y_v = '{8'd3, 8'd30, 8'd200};
        clear_log();
        @(posedge clk); #1;
        req0_a = a_v[0]; req0_b = b_v[0]; req0_op = 5'd0; req0_valid = 1'b1;
        for (int i = 0; i < 300 && k < 3; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                k++;
                @(posedge clk); #1;
                if (k < 3) begin req0_a = a_v[k]; req0_b = b_v[k]; end
                else req0_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        wait_rsps(3, 80);
        total++;
        if (acc_cyc_q.size() !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d required 3", acc_cyc_q.size()); end
        for (int j = 1; j < 3 && j < acc_cyc_q.size(); j++) begin
            lows = 0;
            foreach (busy_low_q[m]) if (busy_low_q[m] > acc_cyc_q[j-1] && busy_low_q[m] <= acc_cyc_q[j]) lows++;
            total++;
            if (acc_cyc_q[j] - acc_cyc_q[j-1] !== 27) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d required 27", j, acc_cyc_q[j] - acc_cyc_q[j-1]); end
            total++;
            if (lows !== 1) begin bad++; $display("FAIL b2b_busy_low[%0d]: got %0d required 1", j, lows); end
        end
        for (int j = 0; j < 3 && j < rsp_y_q.size(); j++) begin
            total++;
            if (rsp_y_q[j] !== y_v[j]) begin bad++; $display("FAIL b2b_y[%0d]: got %0d required %0d", j, rsp_y_q[j], y_v[j]); end
        end
        if (rsp_f_q.size() >= 3) begin
            total++;
            if (rsp_f_q[2] !== 4'b1100) begin bad++; $display("FAIL b2b_flags2: got %b required 1100", rsp_f_q[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_round_robin();
        test_serial_waveform();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
